// File: rtl/avalon_io_byte_slave.sv
// +----------------------------------------------------------------------------+
// | avalon_io_byte_slave: 32-bit Avalon-MM slave serialised onto an 8-bit bus |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module avalon_io_byte_slave #(
  parameter logic [7:0] TIMEOUT   = 8'd255,
  parameter logic [7:0] READ_FILL = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] avs_address,
  input  logic [3:0]  avs_byteenable,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic [15:0] per_address,
  output logic        per_read,
  output logic        per_write,
  output logic [7:0]  per_writedata,
  input  logic [7:0]  per_readdata,
  input  logic        per_ready,
  output logic        timeout_pulse
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic        wr_q, wr_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic        waitreq_q, waitreq_d;
  logic        rdv_q, rdv_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] per_addr_q, per_addr_d;
  logic        per_rd_q, per_rd_d;
  logic        per_wr_q, per_wr_d;
  logic [7:0]  per_wd_q, per_wd_d;
  logic        to_q, to_d;

  logic        launch;
  logic [2:0]  next_l;

  // Word address low bits carry no information; the lane supplies them.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, avs_address[1:0]};

  // Lowest enabled lane at or above 'from'; bit 2 set means none left.
  function automatic logic [2:0] find_lane(input logic [3:0] be, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (be[i] && (i >= int'(from))) res = {1'b0, 2'(i)};
    end
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wd_d       = wd_q;
    wr_d       = wr_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    waitreq_d  = 1'b1;
    rdv_d      = 1'b0;
    rdata_d    = rdata_q;
    per_addr_d = per_addr_q;
    per_rd_d   = 1'b0;
    per_wr_d   = 1'b0;
    per_wd_d   = per_wd_q;
    to_d       = 1'b0;
    launch     = 1'b0;
    next_l     = 3'b100;

    case (state_q)
      IDLE: begin
        if (avs_write || avs_read) begin
          wr_d   = avs_write;
          addr_d = avs_address[15:2];
          be_d   = avs_byteenable;
          wd_d   = avs_writedata;
          acc_d  = {4{READ_FILL}};
          next_l = find_lane(avs_byteenable, 3'd0);
          launch = 1'b1;
        end
      end
      ACCESS: begin
        if (per_ready) begin
          if (!wr_q) acc_d[{lane_q, 3'b000} +: 8] = per_readdata;
          next_l = find_lane(be_q, {1'b0, lane_q} + 3'd1);
          launch = 1'b1;
        end else if (cnt_q == TIMEOUT - 8'd1) begin
          // Aborted read lanes keep the fill byte preloaded at request time.
          to_d   = 1'b1;
          next_l = find_lane(be_q, {1'b0, lane_q} + 3'd1);
          launch = 1'b1;
        end else begin
          cnt_d    = cnt_q + 8'd1;
          per_rd_d = per_rd_q;
          per_wr_d = per_wr_q;
        end
      end
      DONE: begin
        if (wr_q) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
          rdv_d   = 1'b1;
          rdata_d = acc_q;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (launch) begin
      if (next_l[2]) begin
        state_d   = DONE;
        waitreq_d = 1'b0;
      end else begin
        state_d    = ACCESS;
        lane_d     = next_l[1:0];
        cnt_d      = 8'd0;
        per_addr_d = {addr_d, next_l[1:0]};
        per_wd_d   = wd_d[{next_l[1:0], 3'b000} +: 8];
        per_rd_d   = !wr_d;
        per_wr_d   = wr_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wd_q       <= '0;
      wr_q       <= 1'b0;
      lane_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      waitreq_q  <= 1'b1;
      rdv_q      <= 1'b0;
      rdata_q    <= '0;
      per_addr_q <= '0;
      per_rd_q   <= 1'b0;
      per_wr_q   <= 1'b0;
      per_wd_q   <= '0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wd_q       <= wd_d;
      wr_q       <= wr_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      waitreq_q  <= waitreq_d;
      rdv_q      <= rdv_d;
      rdata_q    <= rdata_d;
      per_addr_q <= per_addr_d;
      per_rd_q   <= per_rd_d;
      per_wr_q   <= per_wr_d;
      per_wd_q   <= per_wd_d;
      to_q       <= to_d;
    end
  end

  assign avs_waitrequest   = waitreq_q;
  assign avs_readdatavalid = rdv_q;
  assign avs_readdata      = rdata_q;
  assign per_address       = per_addr_q;
  assign per_read          = per_rd_q;
  assign per_write         = per_wr_q;
  assign per_writedata     = per_wd_q;
  assign timeout_pulse     = to_q;

endmodule

`default_nettype wire
